led_stretch: RTL
================

LED_STRETCH -- requirements
Module: led_stretch

Interface
- REQ-001 Parameter HOLD_MS, default 100: LED on-time in clk_1ms cycles; legal range 1..255.
- REQ-002 Parameter GAP_MS, default 50: minimum LED off-time between blinks in cycles; legal range 0..255.
- REQ-003 Port clk_1ms, input, 1: the single clock, 1 kHz tick clock; all state changes on its rising edge.
- REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
- REQ-005 Port trig, input, 1: event request from internal logic, sampled each rising edge; level-sensitive per cycle.
- REQ-006 Port led, output, 1: registered, human-visible indicator drive.
- REQ-007 Port busy, output, 1: registered; high in HOLD or GAP.
- REQ-008 Port drop, output, 1: registered; single-cycle pulse when a trig is discarded.

Function
- REQ-009 The block SHALL be the output-side counterpart of input debouncing: it stretches 1-cycle events into blinks of at least HOLD_MS ms, separated by at least GAP_MS ms.
- REQ-010 The state machine SHALL have states IDLE, HOLD and GAP.
- REQ-011 IDLE transitions:
  - trig=1 at an edge -> next cycle state=HOLD, led=1, busy=1, counter=HOLD_MS-1.
  - trig=0 -> remain in IDLE.
- REQ-012 HOLD SHALL decrement the counter each cycle; led SHALL be high for exactly HOLD_MS consecutive cycles absent retrigger.
- REQ-013 HOLD exit at counter=0:
  - GAP_MS>0 -> GAP with counter=GAP_MS-1 and led=0.
  - GAP_MS=0 -> proceed directly as in REQ-014 (exit-GAP behaviour).
- REQ-014 GAP exit at counter=0:
  - pending=1 -> HOLD, counter=HOLD_MS-1, pending cleared.
  - pending=0 -> IDLE, busy=0.
- REQ-015 Pending is a one-deep flag. A trig arriving while pending=1, and not absorbed per Configuration, SHALL leave pending at 1 and pulse drop for one cycle.
- REQ-016 Simultaneous events: trig on the same edge as GAP expiry with pending=0 SHALL go straight to HOLD (no IDLE cycle). With pending=1, the same trig SHALL set drop and re-set pending.
- REQ-017 The counter SHALL be 8 bits and SHALL never wrap. Decrement occurs only when the counter is nonzero.

Reset
- REQ-018 rst_n=0 SHALL immediately force state=IDLE, counter=0, pending=0, led=0, busy=0, drop=0, regardless of clock.
- REQ-019 A reset mid-HOLD or mid-GAP SHALL abort the blink with no residual pending. The first trig after release behaves as from IDLE.

Configuration
- REQ-020 Macro LED_STRETCH_RETRIG_EN: when defined, trig in HOLD SHALL reload counter=HOLD_MS-1 (extending the blink) without setting pending or drop. trig in GAP SHALL set pending.
- REQ-021 Without LED_STRETCH_RETRIG_EN, trig in HOLD or GAP SHALL set pending, or pulse drop if pending is already set.

Structure
- REQ-022 Package led_stretch_pkg SHALL hold the state encoding (IDLE=2'd0, HOLD=2'd1, GAP=2'd2) and the constant CNT_W=8.
- REQ-023 Sub-module ms_downcnt (loadable 8-bit down-counter with zero flag) SHALL be used. The FSM stays in led_stretch.
- REQ-024 Unused state 2'd3 SHALL recover to IDLE on the next edge.

Verification (HOLD_MS=5, GAP_MS=3 unless stated)
- REQ-025 1-cycle trig at cycle 10 -> led high cycles 11-15, busy high 11-18, back to IDLE at 19, drop never asserted.
- REQ-026 Macro off: trigs at cycles 10, 12, 13 -> pending set at 12, drop pulse at 14, second blink led high 19-23.
- REQ-027 Macro on: trigs at 10 and 13 -> led high continuously 11-18, single blink, no drop.
- REQ-028 GAP_MS=0: trigs at 10 and 12 -> led high 11-15, then 16-20 with no low cycle between.
- REQ-029 rst_n low at cycle 13 during HOLD with pending set -> led, busy, drop all 0 asynchronously; trig at 20 -> normal blink 21-25.
- REQ-030 trig held high continuously, macro off -> blinks on 5 / off 3 repeating, drop pulsing every cycle pending is already set.

Source files
------------

// File: rtl/led_stretch_pkg.sv
// Shared definitions for the LED pulse stretcher: state encoding,
// counter width and a helper that turns a millisecond count into the
// value loaded into the down-counter.
package led_stretch_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // A phase of N ms is N counter values: N-1 down to 0. A zero-length
    // phase is never entered, so its load value is simply 0.
    function automatic logic [CNT_W-1:0] ms_to_load(input int ms);
        return (ms > 0) ? CNT_W'(ms - 1) : '0;
    endfunction

endpackage

// File: rtl/ms_downcnt.sv
// Loadable 8-bit millisecond down-counter with a zero flag.
// Load has priority over decrement; the count saturates at zero.
module ms_downcnt
    import led_stretch_pkg::*;
(
    input  logic             clk_1ms,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: load, or step down while nonzero so it never wraps.
    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_stretch.sv
// LED pulse stretcher: turns single-cycle trig events into blinks of
// HOLD_MS ms separated by at least GAP_MS ms off-time. One extra event
// may be queued in a pending flag; further events are reported on drop.
// Optional build macro LED_STRETCH_RETRIG_EN: a trig during HOLD restarts
// the on-time instead of queueing.
//
// Interface contract: trig is a level sampled on every clk_1ms rising
// edge (one event per high cycle, no handshake); drop is a one-cycle
// pulse for each event that could not be queued; led and busy are
// registered and change only on clock edges or reset.
module led_stretch
    import led_stretch_pkg::*;
#(
    parameter int HOLD_MS = 100,
    parameter int GAP_MS  = 50
) (
    input  logic clk_1ms,
    input  logic rst_n,
    input  logic trig,
    output logic led,
    output logic busy,
    output logic drop
);

`ifdef LED_STRETCH_RETRIG_EN
    localparam bit RETRIG_EN = 1'b1;
`else
    localparam bit RETRIG_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] HOLD_LOAD = ms_to_load(HOLD_MS);
    localparam logic [CNT_W-1:0] GAP_LOAD  = ms_to_load(GAP_MS);

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic             drop_d;
    logic             led_q, busy_q, drop_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    ms_downcnt u_cnt (
        .clk_1ms  (clk_1ms),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next state, pending flag, drop and counter control.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        drop_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = HOLD_LOAD;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                pending_d = 1'b0;
                if (trig) begin
                    state_d  = HOLD;
                    cnt_load = 1'b1;
                end
            end

            HOLD: begin
                if (RETRIG_EN && trig) begin
                    // Restart the on-time; the event is absorbed.
                    cnt_load = 1'b1;
                end else if (!cnt_zero || (GAP_MS > 0)) begin
                    // Still on, or moving into the off-time: queue trig.
                    if (trig) begin
                        if (pending_q) drop_d    = 1'b1;
                        else           pending_d = 1'b1;
                    end
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        state_d      = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                    end
                end else begin
                    // No off-time: behave exactly like the end of GAP.
                    if (pending_q || trig) begin
                        state_d   = HOLD;
                        cnt_load  = 1'b1;
                        pending_d = pending_q & trig;
                        drop_d    = pending_q & trig;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            GAP: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                    if (trig) begin
                        if (pending_q) drop_d    = 1'b1;
                        else           pending_d = 1'b1;
                    end
                end else if (pending_q || trig) begin
                    // Pending consumed into a new blink; a simultaneous
                    // trig is queued again and reported as dropped.
                    state_d   = HOLD;
                    cnt_load  = 1'b1;
                    pending_d = pending_q & trig;
                    drop_d    = pending_q & trig;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                // Unused encoding: return to a clean idle.
                state_d      = IDLE;
                pending_d    = 1'b0;
                cnt_load     = 1'b1;
                cnt_load_val = '0;
            end
        endcase
    end

    // State, pending and registered outputs derived from the next state.
    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            led_q     <= (state_d == HOLD);
            busy_q    <= (state_d != IDLE);
            drop_q    <= drop_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign drop = drop_q;

endmodule
